// File: rtl/note_sequencer.sv
// Step sequencer feeding the synth voice with trig/count_max from a small pattern memory.
// Build option: define SEQ_LOOP_EN to let the loop input wrap playback from the last step to step 0.
module note_sequencer #(
    parameter int STEPS = 8,
    parameter int PW    = 8,
    parameter int LW    = 4,
    parameter int SW    = $clog2(STEPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             loop,
    input  logic             wr_en,
    input  logic [SW-1:0]    wr_addr,
    input  logic [LW+PW:0]   wr_data,
    input  logic [15:0]      tick_div,
    input  logic [LW-1:0]    gap,
    output logic             trig,
    output logic [PW-1:0]    count_max,
    output logic [SW-1:0]    step,
    output logic             busy,
    output logic             done
);

    localparam int DW = 1 + LW + PW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_GATE = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t          state_r;
    logic [DW-1:0]   mem_r [STEPS];
    logic [15:0]     tcnt_r;
    logic [LW-1:0]   dur_r;

    logic [DW-1:0]   rd_entry_s;
    logic            rd_rest_s;
    logic [LW-1:0]   rd_len_s;
    logic [PW-1:0]   rd_pitch_s;
    logic            tick_s;
    logic            dur_end_s;
    logic            last_step_s;
    logic            adv_s;
    logic            loop_active_s;

`ifdef SEQ_LOOP_EN
    assign loop_active_s = loop;
`else
    logic loop_unused_s;
    assign loop_unused_s = loop;
    assign loop_active_s = 1'b0;
`endif

    // Pattern memory: cleared by reset, writable in any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STEPS; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Entry decode, tempo tick and advance decision.
    always_comb begin
        rd_entry_s  = mem_r[step];
        rd_rest_s   = rd_entry_s[DW-1];
        rd_len_s    = rd_entry_s[PW +: LW];
        rd_pitch_s  = rd_entry_s[PW-1:0];
        if ((state_r == ST_GATE) || (state_r == ST_GAP)) begin
            tick_s = (tcnt_r >= tick_div);
        end else begin
            tick_s = 1'b0;
        end
        dur_end_s   = tick_s && (dur_r <= LW'(1));
        last_step_s = (step == SW'(STEPS - 1));
        if (state_r == ST_GAP) begin
            adv_s = dur_end_s;
        end else if (state_r == ST_GATE) begin
            adv_s = dur_end_s && (gap == '0);
        end else begin
            adv_s = 1'b0;
        end
    end

    // Playback FSM with registered outputs; stop outranks start and advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            tcnt_r    <= 16'd0;
            dur_r     <= '0;
            trig      <= 1'b0;
            count_max <= '0;
            step      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (stop) begin
            state_r   <= ST_IDLE;
            tcnt_r    <= 16'd0;
            dur_r     <= '0;
            trig      <= 1'b0;
            step      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (adv_s) begin
            tcnt_r <= 16'd0;
            trig   <= 1'b0;
            if (!last_step_s) begin
                step    <= step + SW'(1);
                state_r <= ST_LOAD;
                done    <= 1'b0;
            end else if (loop_active_s) begin
                step    <= '0;
                state_r <= ST_LOAD;
                done    <= 1'b0;
            end else begin
                step    <= '0;
                state_r <= ST_IDLE;
                busy    <= 1'b0;
                done    <= 1'b1;
            end
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    tcnt_r <= 16'd0;
                    trig   <= 1'b0;
                    if (start) begin
                        state_r <= ST_LOAD;
                        step    <= '0;
                        busy    <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    tcnt_r    <= 16'd0;
                    count_max <= rd_pitch_s;
                    dur_r     <= (rd_len_s == '0) ? LW'(1) : rd_len_s;
                    trig      <= ~rd_rest_s;
                    state_r   <= ST_GATE;
                end
                ST_GATE: begin
                    if (dur_end_s) begin
                        // Non-zero gap here; a zero gap was taken by the advance branch.
                        tcnt_r  <= 16'd0;
                        dur_r   <= gap;
                        trig    <= 1'b0;
                        state_r <= ST_GAP;
                    end else if (tick_s) begin
                        tcnt_r <= 16'd0;
                        dur_r  <= dur_r - LW'(1);
                    end else begin
                        tcnt_r <= tcnt_r + 16'd1;
                    end
                end
                ST_GAP: begin
                    trig <= 1'b0;
                    if (tick_s) begin
                        tcnt_r <= 16'd0;
                        dur_r  <= dur_r - LW'(1);
                    end else begin
                        tcnt_r <= tcnt_r + 16'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    tcnt_r  <= 16'd0;
                    trig    <= 1'b0;
                    step    <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed self-checking bench for note_sequencer; cycle numbers count from the start pulse (cycle 0).
module tb_note_sequencer;

    localparam int STEPS = 8;
    localparam int PW    = 8;
    localparam int LW    = 4;
    localparam int SW    = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             stop;
    logic             loop;
    logic             wr_en;
    logic [SW-1:0]    wr_addr;
    logic [LW+PW:0]   wr_data;
    logic [15:0]      tick_div;
    logic [LW-1:0]    gap;
    logic             trig;
    logic [PW-1:0]    count_max;
    logic [SW-1:0]    step;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;
    int dcnt;

    note_sequencer #(.STEPS(STEPS), .PW(PW), .LW(LW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .tick_div(tick_div), .gap(gap),
        .trig(trig), .count_max(count_max), .step(step), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [SW-1:0] a, input logic r, input logic [LW-1:0] l, input logic [PW-1:0] p);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = {r, l, p};
        cyc(1);
        wr_en   = 1'b0;
    endtask

    // Leaves the bench in cycle 1 (LOAD of step 0).
    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0; wr_en = 1'b0;
        wr_addr = '0; wr_data = '0; tick_div = 16'd0; gap = 4'd0;
        cyc(2);
        check_val("rst_trig", trig, 0);
        check_val("rst_count_max", count_max, 0);
        check_val("rst_step", step, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        rst_n = 1'b1;
        cyc(1);

        // Basic note: len 2, tick_div 3, gap 1
        tick_div = 16'd3; gap = 4'd1;
        wr(3'd0, 1'b0, 4'd2, 8'd5);
        wr(3'd1, 1'b0, 4'd1, 8'd7);
        pulse_start();
        check_val("basic_load_busy", busy, 1);
        check_val("basic_load_trig", trig, 0);
        for (int c = 2; c <= 14; c++) begin
            cyc(1);
            if (c <= 9) begin
                check_val("basic_gate_trig", trig, 1);
                check_val("basic_gate_pitch", count_max, 5);
            end else if (c <= 13) begin
                check_val("basic_gap_trig", trig, 0);
                check_val("basic_gap_step", step, 0);
            end else begin
                check_val("basic_load1_step", step, 1);
                check_val("basic_load1_trig", trig, 0);
                check_val("basic_load1_busy", busy, 1);
            end
        end
        pulse_stop();
        check_val("basic_stop_busy", busy, 0);

        // Full non-looping run: len 1, tick_div 0, gap 0
        tick_div = 16'd0; gap = 4'd0;
        for (int i = 0; i < STEPS; i++) begin
            wr(SW'(i), 1'b0, 4'd1, PW'(i + 1));
        end
        pulse_start();
        dcnt = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) cyc(1);
            if (done) dcnt++;
            if (c <= 16) begin
                if (c % 2 == 1) begin
                    check_val("run_load_step", step, (c - 1) / 2);
                    check_val("run_load_trig", trig, 0);
                end else begin
                    check_val("run_gate_trig", trig, 1);
                    check_val("run_gate_pitch", count_max, c / 2);
                end
            end
            if (c == 17) begin
                check_val("run_done", done, 1);
                check_val("run_end_busy", busy, 0);
                check_val("run_end_step", step, 0);
            end
        end
        check_val("run_done_count", dcnt, 1);
        check_val("run_hold_pitch", count_max, 8);

        // Rest with len 0, then stop mid-GATE of step 3 together with start
        tick_div = 16'd1;
        wr(3'd2, 1'b1, 4'd0, 8'd9);
        pulse_start();
        for (int c = 2; c <= 11; c++) begin
            cyc(1);
            if (c == 6) begin
                check_val("rest_prev_trig", trig, 1);
                check_val("rest_prev_pitch", count_max, 2);
            end
            if (c == 8 || c == 9) begin
                check_val("rest_trig", trig, 0);
                check_val("rest_pitch", count_max, 9);
                check_val("rest_step", step, 2);
                check_val("rest_busy", busy, 1);
            end
            if (c == 10) check_val("rest_next_step", step, 3);
            if (c == 11) begin
                check_val("stop_pre_trig", trig, 1);
                check_val("stop_pre_pitch", count_max, 4);
            end
        end
        stop = 1'b1; start = 1'b1;
        cyc(1);
        stop = 1'b0; start = 1'b0;
        check_val("stop_busy", busy, 0);
        check_val("stop_trig", trig, 0);
        check_val("stop_step", step, 0);
        check_val("stop_done", done, 0);
        cyc(1);
        check_val("stop_start_ignored", busy, 0);
        check_val("stop_no_done", done, 0);

        // Looping behaviour
        tick_div = 16'd0; gap = 4'd0; loop = 1'b1;
        pulse_start();
        cyc(16);
`ifdef SEQ_LOOP_EN
        check_val("loop_wrap_step", step, 0);
        check_val("loop_wrap_busy", busy, 1);
        check_val("loop_wrap_done", done, 0);
        cyc(1);
        check_val("loop_wrap_trig", trig, 1);
        check_val("loop_wrap_pitch", count_max, 1);
        loop = 1'b0;
        dcnt = 0;
        for (int c = 19; c <= 33; c++) begin
            cyc(1);
            if (done) dcnt++;
        end
        check_val("loop_end_done", done, 1);
        check_val("loop_end_count", dcnt, 1);
        check_val("loop_end_busy", busy, 0);
`else
        check_val("noloop_done", done, 1);
        check_val("noloop_busy", busy, 0);
        check_val("noloop_step", step, 0);
`endif
        loop = 1'b0;
        cyc(2);

        // Same-cycle write during LOAD returns the old entry
        tick_div = 16'd0; gap = 4'd2;
        wr(3'd0, 1'b0, 4'd1, 8'h11);
        pulse_start();
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = {1'b0, 4'd1, 8'h22};
        cyc(1);
        wr_en = 1'b0;
        check_val("rbw_old_pitch", count_max, 8'h11);
        check_val("rbw_trig", trig, 1);
        cyc(1);
        check_val("rbw_gap_trig", trig, 0);
        check_val("rbw_gap_busy", busy, 1);
        pulse_stop();
        pulse_start();
        cyc(1);
        check_val("rbw_new_pitch", count_max, 8'h22);
        cyc(1);
        check_val("arst_pre_busy", busy, 1);

        // Asynchronous reset in GAP, then mid-GATE
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_gap_trig", trig, 0);
        check_val("arst_gap_pitch", count_max, 0);
        check_val("arst_gap_busy", busy, 0);
        check_val("arst_gap_step", step, 0);
        check_val("arst_gap_done", done, 0);
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        pulse_start();
        cyc(1);
        check_val("arst_mem_cleared_trig", trig, 1);
        check_val("arst_mem_cleared_pitch", count_max, 0);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_gate_trig", trig, 0);
        check_val("arst_gate_busy", busy, 0);
        cyc(1);
        rst_n = 1'b1;
        cyc(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
